// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : control_pkg
//  Purpose  : Shared definitions for the Cosmic Processing Unit control unit:
//             opcode values, output field encodings and the packed bundle
//             of all decoder outputs.
//  Revision : 1.0  initial release
// ============================================================================
package control_pkg;

    // Instruction opcodes (4-bit field)
    localparam logic [3:0] OP_HALT  = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_BGT   = 4'b0100;
    localparam logic [3:0] OP_BLT   = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_JMP   = 4'b0111;
    localparam logic [3:0] OP_LBU   = 4'b1010;
    localparam logic [3:0] OP_SB    = 4'b1011;
    localparam logic [3:0] OP_LW    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_ATYPE = 4'b1111;

    typedef enum logic [1:0] {
        ALU_FUNC = 2'b00,   // operation taken from the function field
        ALU_AND  = 2'b01,
        ALU_OR   = 2'b10,
        ALU_ADD  = 2'b11
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RW_NONE    = 2'b00,
        RW_OP1     = 2'b01,
        RW_OP1_R15 = 2'b10    // multiply/divide: Op1 plus R15
    } reg_write_e;

    typedef enum logic [1:0] {
        JB_PC2    = 2'b00,
        JB_BRANCH = 2'b01,
        JB_JUMP   = 2'b10,
        JB_HALT   = 2'b11
    } jump_branch_e;

    typedef struct packed {
        logic         alu_b_type;
        logic         alu_src;
        logic         zero_extend;
        logic         mem_read;
        logic         mem_to_reg;
        logic         mem_write;
        alu_ctrl_e    alu_control;
        reg_write_e   reg_write;
        jump_branch_e jump_branch;
    } ctrl_t;

    // All-zero bundle: NOP decode, PC+2
    localparam ctrl_t CTRL_NOP = '0;

endpackage : control_pkg
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
//  Module   : control_decode
//  Purpose  : Pure combinational opcode-to-control decode.
//  Ports    : opcode   in  4   instruction opcode field
//             multiDiv in  2   bit 0 = A-type multiply/divide flag
//             ctrl     out ctrl_t  decoded control bundle
//  Config   : CONTROL_MULTDIV_EN  when defined, multiDiv[0] selects the
//             Op1+R15 write mode for A-type; otherwise multiDiv is unused.
//  Revision : 1.0  initial release
// ============================================================================
module control_decode
    import control_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [1:0] multiDiv,
    output ctrl_t      ctrl
);

    logic w_atype_wide;

`ifdef CONTROL_MULTDIV_EN
    assign w_atype_wide = multiDiv[0];
`else
    assign w_atype_wide = 1'b0;
`endif

    // multiDiv[1] is reserved; multiDiv[0] is only consumed with the macro on
    logic w_unused_md;
    assign w_unused_md = ^multiDiv;

    always_comb begin
        ctrl = CTRL_NOP;
        // An unknown opcode or flag falls back to the NOP decode
        if (!$isunknown({opcode, w_atype_wide})) begin
            case (opcode)
                OP_ATYPE: begin
                    ctrl.alu_control = ALU_FUNC;
                    ctrl.reg_write   = w_atype_wide ? RW_OP1_R15 : RW_OP1;
                end
                OP_ANDI, OP_ORI: begin
                    ctrl.alu_src     = 1'b1;
                    ctrl.zero_extend = 1'b1;
                    ctrl.alu_control = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
                    ctrl.reg_write   = RW_OP1;
                end
                OP_LBU, OP_LW: begin
                    ctrl.alu_src     = 1'b1;
                    ctrl.alu_control = ALU_ADD;
                    ctrl.mem_read    = 1'b1;
                    ctrl.mem_to_reg  = 1'b1;
                    ctrl.reg_write   = RW_OP1;
                end
                OP_SB, OP_SW: begin
                    ctrl.alu_src     = 1'b1;
                    ctrl.alu_control = ALU_ADD;
                    ctrl.mem_write   = 1'b1;
                end
                // Compare type is recovered by the datapath from the opcode
                OP_BLT, OP_BGT, OP_BEQ: begin
                    ctrl.alu_b_type  = 1'b1;
                    ctrl.jump_branch = JB_BRANCH;
                end
                OP_JMP:  ctrl.jump_branch = JB_JUMP;
                OP_HALT: ctrl.jump_branch = JB_HALT;
                default: ctrl = CTRL_NOP;
            endcase
        end
    end

endmodule : control_decode
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Purpose  : Main instruction decoder of the Cosmic Processing Unit.
//             Combinational decode followed by one output register stage
//             (latency 1 clock, one opcode accepted per cycle).
//  Ports    : clk            in  1  system clock
//             rst            in  1  synchronous active-high reset
//             opcode         in  4  instruction opcode
//             multiDiv       in  2  bit 0 = A-type mult/div flag
//             aluBType       out 1  ALU compare for branch
//             aluSrc         out 1  operand B: 0 reg, 1 immediate
//             zeroExtendFlag out 1  1 zero-extend, 0 sign-extend
//             memRead        out 1  data-memory read strobe
//             memToReg       out 1  write-back from memory
//             memWrite       out 1  data-memory write strobe
//             aluControl     out 2  ALU operation select
//             regWrite       out 2  register-file write mode
//             jumpBranch     out 2  PC sequencing
//  Config   : CONTROL_MULTDIV_EN  enables the A-type Op1+R15 write mode.
//  Revision : 1.0  initial release
// ============================================================================
module control_unit
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic [1:0] multiDiv,
    output logic       aluBType,
    output logic       aluSrc,
    output logic       zeroExtendFlag,
    output logic       memRead,
    output logic       memToReg,
    output logic       memWrite,
    output logic [1:0] aluControl,
    output logic [1:0] regWrite,
    output logic [1:0] jumpBranch
);

    ctrl_t w_ctrl;
    ctrl_t r_ctrl;

    control_decode u_decode (
        .opcode   (opcode),
        .multiDiv (multiDiv),
        .ctrl     (w_ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= CTRL_NOP;
        end else begin
            r_ctrl <= w_ctrl;
        end
    end

    assign aluBType       = r_ctrl.alu_b_type;
    assign aluSrc         = r_ctrl.alu_src;
    assign zeroExtendFlag = r_ctrl.zero_extend;
    assign memRead        = r_ctrl.mem_read;
    assign memToReg       = r_ctrl.mem_to_reg;
    assign memWrite       = r_ctrl.mem_write;
    assign aluControl     = r_ctrl.alu_control;
    assign regWrite       = r_ctrl.reg_write;
    assign jumpBranch     = r_ctrl.jump_branch;

endmodule : control_unit
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_unit
//  Purpose  : Self-checking bench for control_unit. Expected outputs come
//             from an opcode-class reference model; stimulus is directed
//             plus $urandom sequences with occasional mid-stream resets.
//  Config   : CONTROL_MULTDIV_EN  mirrors the design build option.
//  Revision : 1.0  initial release
// ============================================================================
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic [1:0] multiDiv;
    logic       aluBType, aluSrc, zeroExtendFlag, memRead, memToReg, memWrite;
    logic [1:0] aluControl, regWrite, jumpBranch;

    int n_cmp;
    int n_err;

    control_unit dut (
        .clk            (clk),
        .rst            (rst),
        .opcode         (opcode),
        .multiDiv       (multiDiv),
        .aluBType       (aluBType),
        .aluSrc         (aluSrc),
        .zeroExtendFlag (zeroExtendFlag),
        .memRead        (memRead),
        .memToReg       (memToReg),
        .memWrite       (memWrite),
        .aluControl     (aluControl),
        .regWrite       (regWrite),
        .jumpBranch     (jumpBranch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {aluBType,aluSrc,zext,memRead,memToReg,
    // memWrite,aluControl,regWrite,jumpBranch}
    logic [11:0] w_got;
    assign w_got = {aluBType, aluSrc, zeroExtendFlag, memRead, memToReg,
                    memWrite, aluControl, regWrite, jumpBranch};

    // Reference model: classify the opcode, then derive each field
    function automatic logic [11:0] model(input logic [3:0] op, input logic [1:0] md);
        bit is_load, is_store, is_br, is_logic, is_atype, md_en;
        logic [1:0] alu, rw, jb;
        is_load  = (op == 4'd10) || (op == 4'd12);
        is_store = (op == 4'd11) || (op == 4'd13);
        is_br    = (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
        is_logic = (op == 4'd1) || (op == 4'd2);
        is_atype = (op == 4'd15);
`ifdef CONTROL_MULTDIV_EN
        md_en = 1'b1;
`else
        md_en = 1'b0;
`endif
        if (op == 4'd1)               alu = 2'd1;
        else if (op == 4'd2)          alu = 2'd2;
        else if (is_load || is_store) alu = 2'd3;
        else                          alu = 2'd0;
        if (is_atype)                 rw = (md_en && md[0]) ? 2'd2 : 2'd1;
        else if (is_logic || is_load) rw = 2'd1;
        else                          rw = 2'd0;
        if (is_br)                    jb = 2'd1;
        else if (op == 4'd7)          jb = 2'd2;
        else if (op == 4'd0)          jb = 2'd3;
        else                          jb = 2'd0;
        return {is_br, is_load || is_store || is_logic, is_logic,
                is_load, is_load, is_store, alu, rw, jb};
    endfunction

    task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %03h expected %03h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, check after the rising edge
    task automatic step(input string tag, input logic r, input logic [3:0] op, input logic [1:0] md);
        logic [11:0] exp;
        @(negedge clk);
        rst      = r;
        opcode   = op;
        multiDiv = md;
        @(posedge clk);
        #1;
        exp = r ? 12'h000 : model(op, md);
        check_val(tag, w_got, exp);
        check_val("mem_excl", {11'd0, memRead & memWrite}, 12'h000);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        opcode   = 4'hF;
        multiDiv = 2'b00;

        // Reset held two cycles with an A-type opcode present
        step("reset0", 1'b1, 4'hF, 2'b00);
        step("reset1", 1'b1, 4'hF, 2'b00);
        step("post_reset", 1'b0, 4'hF, 2'b00);

        // A-type with and without the mult/div flag
        step("atype_md1", 1'b0, 4'hF, 2'b01);
        step("atype_md0", 1'b0, 4'hF, 2'b00);
        step("atype_md2", 1'b0, 4'hF, 2'b10);
        step("atype_md3", 1'b0, 4'hF, 2'b11);

        // Sweep of all opcodes back-to-back, flag set to show it is ignored
        for (int i = 0; i < 16; i++) begin
            step("sweep", 1'b0, 4'(i), 2'b01);
        end
        for (int i = 15; i >= 0; i--) begin
            step("sweep_rev", 1'b0, 4'(i), 2'b00);
        end

        // Mid-stream reset discards the pending decode
        step("pre_rst", 1'b0, 4'hA, 2'b00);
        step("mid_rst", 1'b1, 4'h0, 2'b00);
        step("after_rst", 1'b0, 4'h7, 2'b00);

        // Random stream with occasional resets
        for (int i = 0; i < 300; i++) begin
            logic r;
            r = ($urandom_range(0, 19) == 0);
            step("rand", r, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_control_unit
`default_nettype wire
